// File: rtl/ofs_fim_axis_pipe_pkg.sv
// Shared types and helpers for AXIS pipeline buffers.
package ofs_fim_axis_pipe_pkg;
  import ofs_fim_if_pkg::*;

  // One AXIS beat at the default PCIe TX widths. Buffers built with other
  // widths declare a local struct with the same field order.
  typedef struct packed {
    logic [AXIS_PCIE_DW-1:0]    tdata;
    logic                       tlast;
    logic [AXIS_PCIE_TX_UW-1:0] tuser;
  } t_axis_beat;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/ofs_fim_if_pkg.sv
// Interface-level width defaults for the AXIS PCIe TX path.
package ofs_fim_if_pkg;
  localparam int AXIS_PCIE_DW    = 512;
  localparam int AXIS_PCIE_TX_UW = 8;
endpackage

// File: rtl/axis_pipe_ram.sv
// DEPTH-entry register array: synchronous write, asynchronous read.
module axis_pipe_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_pcie_tx_elastic_pipe.sv
// Elastic AXIS TX buffer between the TX arbiter and the PCIe IP.
// MODE 0 forwards as soon as a beat lands; MODE 1 holds beats until a whole
// packet is buffered, falling back to cut-through for packets longer than
// the buffer so the pipe can never wedge.
module axis_pcie_tx_elastic_pipe
  import ofs_fim_if_pkg::*;
  import ofs_fim_axis_pipe_pkg::*;
#(
  parameter  int TDATA_WIDTH    = AXIS_PCIE_DW,
  parameter  int TUSER_WIDTH    = AXIS_PCIE_TX_UW,
  parameter  int DEPTH          = 4,
  parameter  int MODE           = 0,
  parameter  int AFULL_THRESH   = DEPTH - 1,
  parameter  bit TREADY_RST_VAL = 1'b0,
  localparam int PW             = $clog2(DEPTH),
  localparam int OW             = $clog2(DEPTH + 1)
) (
  input  logic                   s_if_clk,
  input  logic                   s_if_rst_n,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic [TUSER_WIDTH-1:0] s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [TUSER_WIDTH-1:0] m_tuser,
  output logic [OW-1:0]          occupancy,
  output logic                   almost_full,
  output logic [OW-1:0]          pkt_cnt,
  output logic                   err_pkt_too_long
);
  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
  } beat_t;

  generate
    if (!is_pow2(DEPTH)) begin : g_depth_chk
      $error("axis_pcie_tx_elastic_pipe: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ_q, occ_nxt, pkt_q, pkt_nxt;
  logic          rdy_q, afull_q, fallback, err_q;
  logic          wr, rd, pkt_inc, pkt_dec;
  beat_t         wbeat, rbeat;

  assign wbeat = '{tdata: s_tdata, tlast: s_tlast, tuser: s_tuser};

  axis_pipe_ram #(.WIDTH($bits(beat_t)), .DEPTH(DEPTH)) u_ram (
    .clk  (s_if_clk),
    .we   (wr),
    .waddr(wr_ptr),
    .wdata(wbeat),
    .raddr(rd_ptr),
    .rdata(rbeat)
  );

  // Handshakes; ready and valid come from registered state only.
  always_comb begin
    s_tready = rdy_q;
    m_tvalid = (occ_q != '0) & ((MODE == 0) | (pkt_q != '0) | fallback);
    wr       = s_tvalid & rdy_q;
    rd       = m_tvalid & m_tready;
    pkt_inc  = wr & s_tlast;
    pkt_dec  = rd & rbeat.tlast;
  end

  // Next occupancy and packet count; simultaneous in/out cancel.
  always_comb begin
    occ_nxt = occ_q;
    pkt_nxt = pkt_q;
    if (wr & ~rd)      occ_nxt = occ_q + 1'b1;
    else if (rd & ~wr) occ_nxt = occ_q - 1'b1;
    if (pkt_inc & ~pkt_dec)      pkt_nxt = pkt_q + 1'b1;
    else if (pkt_dec & ~pkt_inc) pkt_nxt = pkt_q - 1'b1;
  end

  // Pointers, counters, flow-control status and the oversize-packet escape.
  always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
    if (!s_if_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      rdy_q    <= TREADY_RST_VAL;
      afull_q  <= 1'b0;
      fallback <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      occ_q   <= occ_nxt;
      pkt_q   <= pkt_nxt;
      rdy_q   <= (occ_nxt != OW'(DEPTH));
      afull_q <= (occ_nxt >= OW'(AFULL_THRESH));
      // A full buffer with no complete packet can only be a packet longer
      // than DEPTH: let it drain cut-through until its tail leaves.
      if (MODE == 1) begin
        if (pkt_dec) begin
          fallback <= 1'b0;
        end else if ((occ_q == OW'(DEPTH)) && (pkt_q == '0)) begin
          fallback <= 1'b1;
          err_q    <= 1'b1;
        end
      end
    end
  end

  assign m_tdata          = rbeat.tdata;
  assign m_tlast          = rbeat.tlast;
  assign m_tuser          = rbeat.tuser;
  assign occupancy        = occ_q;
  assign pkt_cnt          = pkt_q;
  assign almost_full      = afull_q;
  assign err_pkt_too_long = err_q;
endmodule

// File: tb/tb_axis_pcie_tx_elastic_pipe.sv
// Directed and randomized checks of the elastic pipe in both modes.
module tb_axis_pcie_tx_elastic_pipe;
  localparam int DW = 16;
  localparam int UW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic          s0_tvalid, s0_tready, s0_tlast, m0_tvalid, m0_tready, m0_tlast, af0, err0;
  logic [DW-1:0] s0_tdata, m0_tdata;
  logic [UW-1:0] s0_tuser, m0_tuser;
  logic [2:0]    occ0, pkt0;
  logic          s1_tvalid, s1_tready, s1_tlast, m1_tvalid, m1_tready, m1_tlast, af1, err1;
  logic [DW-1:0] s1_tdata, m1_tdata;
  logic [UW-1:0] s1_tuser, m1_tuser;
  logic [2:0]    occ1, pkt1;

  axis_pcie_tx_elastic_pipe #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH(4), .MODE(0),
                              .TREADY_RST_VAL(1'b0)) u_ct (
    .s_if_clk(clk), .s_if_rst_n(rst_n),
    .s_tvalid(s0_tvalid), .s_tready(s0_tready), .s_tdata(s0_tdata), .s_tlast(s0_tlast), .s_tuser(s0_tuser),
    .m_tvalid(m0_tvalid), .m_tready(m0_tready), .m_tdata(m0_tdata), .m_tlast(m0_tlast), .m_tuser(m0_tuser),
    .occupancy(occ0), .almost_full(af0), .pkt_cnt(pkt0), .err_pkt_too_long(err0));

  axis_pcie_tx_elastic_pipe #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH(4), .MODE(1),
                              .TREADY_RST_VAL(1'b0)) u_sf (
    .s_if_clk(clk), .s_if_rst_n(rst_n),
    .s_tvalid(s1_tvalid), .s_tready(s1_tready), .s_tdata(s1_tdata), .s_tlast(s1_tlast), .s_tuser(s1_tuser),
    .m_tvalid(m1_tvalid), .m_tready(m1_tready), .m_tdata(m1_tdata), .m_tlast(m1_tlast), .m_tuser(m1_tuser),
    .occupancy(occ1), .almost_full(af1), .pkt_cnt(pkt1), .err_pkt_too_long(err1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_tvalid = 0; s0_tdata = '0; s0_tlast = 0; s0_tuser = '0; m0_tready = 0;
    s1_tvalid = 0; s1_tdata = '0; s1_tlast = 0; s1_tuser = '0; m1_tready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    checks++;
    if ({m0_tvalid, s0_tready, occ0, pkt0, af0, err0} !== 10'b0) begin
      errors++; $display("FAIL reset_ct got v=%b r=%b occ=%0d pkt=%0d af=%b err=%b exp all 0",
                         m0_tvalid, s0_tready, occ0, pkt0, af0, err0);
    end
    checks++;
    if ({m1_tvalid, s1_tready, occ1, pkt1, af1, err1} !== 10'b0) begin
      errors++; $display("FAIL reset_sf got v=%b r=%b occ=%0d pkt=%0d af=%b err=%b exp all 0",
                         m1_tvalid, s1_tready, occ1, pkt1, af1, err1);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (s0_tready !== 1'b1 || s1_tready !== 1'b1) begin
      errors++; $display("FAIL reset_release_tready got %b/%b exp 1/1", s0_tready, s1_tready);
    end
  endtask

  task automatic test_cut_through();
    m0_tready = 1;
    for (int i = 0; i < 8; i++) begin
      s0_tvalid = 1; s0_tdata = 16'(16'h0100 + i); s0_tlast = (i == 7); s0_tuser = 4'(i);
      checks++;
      if (s0_tready !== 1'b1) begin
        errors++; $display("FAIL ct_tready beat %0d got %b exp 1", i, s0_tready);
      end
      tick();
      checks++;
      if (m0_tvalid !== 1'b1 || m0_tdata !== 16'(16'h0100 + i) || m0_tuser !== 4'(i) ||
          m0_tlast !== (i == 7) || occ0 !== 3'd1) begin
        errors++; $display("FAIL ct_out beat %0d got v=%b d=%h u=%h l=%b occ=%0d exp v=1 d=%h u=%h l=%b occ=1",
                           i, m0_tvalid, m0_tdata, m0_tuser, m0_tlast, occ0, 16'(16'h0100 + i), 4'(i), (i == 7));
      end
    end
    s0_tvalid = 0; s0_tlast = 0;
    tick();
    checks++;
    if (m0_tvalid !== 1'b0 || occ0 !== 3'd0 || pkt0 !== 3'd0) begin
      errors++; $display("FAIL ct_drain got v=%b occ=%0d pkt=%0d exp 0/0/0", m0_tvalid, occ0, pkt0);
    end
  endtask

  task automatic test_full_stall();
    int exp_occ;
    m0_tready = 0;
    for (int i = 0; i < 5; i++) begin
      s0_tvalid = 1; s0_tdata = 16'(16'h0200 + i); s0_tlast = (i == 3); s0_tuser = 4'(i);
      checks++;
      if (s0_tready !== (i < 4)) begin
        errors++; $display("FAIL fs_tready push %0d got %b exp %b", i, s0_tready, (i < 4));
      end
      tick();
      exp_occ = (i < 4) ? i + 1 : 4;
      checks++;
      if (occ0 !== 3'(exp_occ) || af0 !== (exp_occ >= 3) || m0_tvalid !== 1'b1 || m0_tdata !== 16'h0200) begin
        errors++; $display("FAIL fs_fill push %0d got occ=%0d af=%b v=%b d=%h exp occ=%0d af=%b v=1 d=0200",
                           i, occ0, af0, m0_tvalid, m0_tdata, exp_occ, (exp_occ >= 3));
      end
    end
    s0_tvalid = 0; s0_tlast = 0;
    tick();
    checks++;
    if (s0_tready !== 1'b0 || m0_tdata !== 16'h0200 || occ0 !== 3'd4) begin
      errors++; $display("FAIL fs_hold got r=%b d=%h occ=%0d exp r=0 d=0200 occ=4", s0_tready, m0_tdata, occ0);
    end
    m0_tready = 1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (m0_tvalid !== 1'b1 || m0_tdata !== 16'(16'h0200 + j) || m0_tlast !== (j == 3) ||
          s0_tready !== (j != 0)) begin
        errors++; $display("FAIL fs_release %0d got v=%b d=%h l=%b r=%b exp v=1 d=%h l=%b r=%b",
                           j, m0_tvalid, m0_tdata, m0_tlast, s0_tready, 16'(16'h0200 + j), (j == 3), (j != 0));
      end
      tick();
    end
    checks++;
    if (m0_tvalid !== 1'b0 || occ0 !== 3'd0 || af0 !== 1'b0 || s0_tready !== 1'b1) begin
      errors++; $display("FAIL fs_empty got v=%b occ=%0d af=%b r=%b exp 0/0/0/1", m0_tvalid, occ0, af0, s0_tready);
    end
  endtask

  task automatic test_store_forward();
    m1_tready = 1;
    checks++;
    if (err1 !== 1'b0) begin
      errors++; $display("FAIL sf_err_initial got %b exp 0", err1);
    end
    for (int i = 0; i < 3; i++) begin
      s1_tvalid = 1; s1_tdata = 16'(16'h0300 + i); s1_tlast = (i == 2); s1_tuser = 4'(i);
      checks++;
      if (m1_tvalid !== 1'b0 || s1_tready !== 1'b1) begin
        errors++; $display("FAIL sf_hold beat %0d got v=%b r=%b exp v=0 r=1", i, m1_tvalid, s1_tready);
      end
      tick();
      checks++;
      if (pkt1 !== 3'((i == 2) ? 1 : 0)) begin
        errors++; $display("FAIL sf_pkt beat %0d got %0d exp %0d", i, pkt1, (i == 2) ? 1 : 0);
      end
    end
    s1_tvalid = 0; s1_tlast = 0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (m1_tvalid !== 1'b1 || m1_tdata !== 16'(16'h0300 + j) || pkt1 !== 3'd1) begin
        errors++; $display("FAIL sf_out %0d got v=%b d=%h pkt=%0d exp v=1 d=%h pkt=1",
                           j, m1_tvalid, m1_tdata, pkt1, 16'(16'h0300 + j));
      end
      tick();
    end
    checks++;
    if (m1_tvalid !== 1'b0 || pkt1 !== 3'd0 || occ1 !== 3'd0) begin
      errors++; $display("FAIL sf_drain got v=%b pkt=%0d occ=%0d exp 0/0/0", m1_tvalid, pkt1, occ1);
    end
  endtask

  task automatic test_too_long();
    int in_idx, out_idx;
    bit wr, rd;
    in_idx = 0; out_idx = 0;
    m1_tready = 1;
    for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
      s1_tvalid = (in_idx < 6); s1_tdata = 16'(16'h0400 + in_idx); s1_tlast = (in_idx == 5); s1_tuser = 4'(in_idx);
      wr = s1_tvalid && s1_tready;
      rd = m1_tvalid && m1_tready;
      if (rd) begin
        checks++;
        if (m1_tdata !== 16'(16'h0400 + out_idx) || m1_tlast !== (out_idx == 5) || err1 !== 1'b1) begin
          errors++; $display("FAIL tl_out %0d got d=%h l=%b err=%b exp d=%h l=%b err=1",
                             out_idx, m1_tdata, m1_tlast, err1, 16'(16'h0400 + out_idx), (out_idx == 5));
        end
        out_idx++;
      end
      tick();
      if (wr) in_idx++;
    end
    s1_tvalid = 0; s1_tlast = 0;
    checks++;
    if (out_idx != 6) begin
      errors++; $display("FAIL tl_timeout got %0d beats out exp 6", out_idx);
    end
    checks++;
    if (err1 !== 1'b1 || occ1 !== 3'd0 || pkt1 !== 3'd0 || m1_tvalid !== 1'b0) begin
      errors++; $display("FAIL tl_end got err=%b occ=%0d pkt=%0d v=%b exp 1/0/0/0", err1, occ1, pkt1, m1_tvalid);
    end
    repeat (3) tick();
    checks++;
    if (err1 !== 1'b1) begin
      errors++; $display("FAIL tl_err_sticky got %b exp 1", err1);
    end
  endtask

  task automatic test_simul();
    m0_tready = 0;
    for (int i = 0; i < 2; i++) begin
      s0_tvalid = 1; s0_tdata = 16'(16'h0500 + i); s0_tlast = 0; s0_tuser = '0;
      tick();
    end
    checks++;
    if (occ0 !== 3'd2) begin
      errors++; $display("FAIL sim_fill2 got occ=%0d exp 2", occ0);
    end
    s0_tdata = 16'h0502; m0_tready = 1;
    tick();
    checks++;
    if (occ0 !== 3'd2 || m0_tdata !== 16'h0501) begin
      errors++; $display("FAIL sim_rdwr got occ=%0d d=%h exp occ=2 d=0501", occ0, m0_tdata);
    end
    m0_tready = 0;
    for (int i = 3; i < 5; i++) begin
      s0_tdata = 16'(16'h0500 + i);
      tick();
    end
    checks++;
    if (occ0 !== 3'd4 || s0_tready !== 1'b0) begin
      errors++; $display("FAIL sim_full got occ=%0d r=%b exp occ=4 r=0", occ0, s0_tready);
    end
    s0_tdata = 16'h0505; m0_tready = 1;
    tick();
    checks++;
    if (occ0 !== 3'd3 || s0_tready !== 1'b1 || m0_tdata !== 16'h0502) begin
      errors++; $display("FAIL sim_full_rd got occ=%0d r=%b d=%h exp occ=3 r=1 d=0502", occ0, s0_tready, m0_tdata);
    end
    tick();
    s0_tvalid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m0_tvalid !== 1'b1 || m0_tdata !== 16'(16'h0503 + k)) begin
        errors++; $display("FAIL sim_drain %0d got v=%b d=%h exp v=1 d=%h", k, m0_tvalid, m0_tdata, 16'(16'h0503 + k));
      end
      tick();
    end
    checks++;
    if (occ0 !== 3'd0 || m0_tvalid !== 1'b0) begin
      errors++; $display("FAIL sim_empty got occ=%0d v=%b exp 0/0", occ0, m0_tvalid);
    end
  endtask

  task automatic test_random();
    logic [20:0] q0[$];
    logic [20:0] q1[$];
    int  beats0, cyc, n0, n1;
    bit  wr0, rd0, wr1, rd1;
    beats0 = 0; cyc = 0; wr0 = 0; wr1 = 0;
    while (beats0 < 10000 && cyc < 60000) begin
      if (!s0_tvalid || wr0) begin
        s0_tvalid = ($urandom_range(0, 3) != 0); s0_tdata = 16'($urandom);
        s0_tlast = ($urandom_range(0, 3) == 0); s0_tuser = 4'($urandom);
      end
      if (!s1_tvalid || wr1) begin
        s1_tvalid = ($urandom_range(0, 3) != 0); s1_tdata = 16'($urandom);
        s1_tlast = ($urandom_range(0, 3) == 0); s1_tuser = 4'($urandom);
      end
      m0_tready = ($urandom_range(0, 3) != 0);
      m1_tready = ($urandom_range(0, 3) != 0);
      wr0 = s0_tvalid && s0_tready; rd0 = m0_tvalid && m0_tready;
      wr1 = s1_tvalid && s1_tready; rd1 = m1_tvalid && m1_tready;
      if (rd0) begin
        checks++;
        if (q0.size() == 0 || {m0_tdata, m0_tlast, m0_tuser} !== q0[0]) begin
          errors++; $display("FAIL rnd_ct_data cyc %0d got %h exp %h (q=%0d)", cyc, {m0_tdata, m0_tlast, m0_tuser},
                             (q0.size() != 0) ? q0[0] : 21'h0, q0.size());
        end
      end
      if (rd1) begin
        checks++;
        if (q1.size() == 0 || {m1_tdata, m1_tlast, m1_tuser} !== q1[0]) begin
          errors++; $display("FAIL rnd_sf_data cyc %0d got %h exp %h (q=%0d)", cyc, {m1_tdata, m1_tlast, m1_tuser},
                             (q1.size() != 0) ? q1[0] : 21'h0, q1.size());
        end
      end
      tick();
      cyc++;
      if (rd0 && q0.size() != 0) begin void'(q0.pop_front()); beats0++; end
      if (rd1 && q1.size() != 0) void'(q1.pop_front());
      if (wr0) q0.push_back({s0_tdata, s0_tlast, s0_tuser});
      if (wr1) q1.push_back({s1_tdata, s1_tlast, s1_tuser});
      n0 = 0; n1 = 0;
      foreach (q0[k]) n0 += int'(q0[k][4]);
      foreach (q1[k]) n1 += int'(q1[k][4]);
      checks++;
      if (int'(occ0) != q0.size() || int'(pkt0) != n0 || m0_tvalid !== (q0.size() != 0) ||
          s0_tready !== (q0.size() != 4)) begin
        errors++; $display("FAIL rnd_ct_state cyc %0d got occ=%0d pkt=%0d v=%b r=%b exp occ=%0d pkt=%0d v=%b r=%b",
                           cyc, occ0, pkt0, m0_tvalid, s0_tready, q0.size(), n0, (q0.size() != 0), (q0.size() != 4));
      end
      checks++;
      if (int'(occ1) != q1.size() || int'(pkt1) != n1) begin
        errors++; $display("FAIL rnd_sf_state cyc %0d got occ=%0d pkt=%0d exp occ=%0d pkt=%0d",
                           cyc, occ1, pkt1, q1.size(), n1);
      end
    end
    checks++;
    if (beats0 < 10000) begin
      errors++; $display("FAIL rnd_timeout got %0d beats exp 10000", beats0);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst_n = 0;
    tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      s0_tvalid = 1; s0_tdata = 16'(16'h0600 + i);
      s1_tvalid = 1; s1_tdata = 16'(16'h0600 + i);
      tick();
    end
    s0_tvalid = 0; s1_tvalid = 0;
    checks++;
    if (occ0 !== 3'd3 || occ1 !== 3'd3) begin
      errors++; $display("FAIL rm_fill got occ=%0d/%0d exp 3/3", occ0, occ1);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({m0_tvalid, s0_tready, occ0, pkt0, af0, err0, m1_tvalid, s1_tready, occ1, pkt1, af1, err1} !== 20'b0) begin
      errors++; $display("FAIL rm_async got ct v=%b r=%b occ=%0d af=%b sf v=%b r=%b occ=%0d af=%b exp all 0",
                         m0_tvalid, s0_tready, occ0, af0, m1_tvalid, s1_tready, occ1, af1);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (s0_tready !== 1'b1 || s1_tready !== 1'b1 || m0_tvalid !== 1'b0 || m1_tvalid !== 1'b0) begin
      errors++; $display("FAIL rm_release got r=%b/%b v=%b/%b exp r=1/1 v=0/0", s0_tready, s1_tready, m0_tvalid, m1_tvalid);
    end
    m0_tready = 1; m1_tready = 1;
    repeat (2) tick();
    checks++;
    if (m0_tvalid !== 1'b0 || m1_tvalid !== 1'b0 || occ0 !== 3'd0 || occ1 !== 3'd0) begin
      errors++; $display("FAIL rm_no_stale got v=%b/%b occ=%0d/%0d exp 0", m0_tvalid, m1_tvalid, occ0, occ1);
    end
    s0_tvalid = 1; s0_tdata = 16'h06AA; s0_tlast = 1;
    s1_tvalid = 1; s1_tdata = 16'h06AA; s1_tlast = 1;
    tick();
    s0_tvalid = 0; s1_tvalid = 0;
    checks++;
    if (m0_tvalid !== 1'b1 || m0_tdata !== 16'h06AA || m1_tvalid !== 1'b1 || m1_tdata !== 16'h06AA) begin
      errors++; $display("FAIL rm_fresh got v=%b/%b d=%h/%h exp v=1/1 d=06aa", m0_tvalid, m1_tvalid, m0_tdata, m1_tdata);
    end
    tick();
    checks++;
    if (occ0 !== 3'd0 || occ1 !== 3'd0 || pkt1 !== 3'd0) begin
      errors++; $display("FAIL rm_final got occ=%0d/%0d pkt=%0d exp 0/0/0", occ0, occ1, pkt1);
    end
  endtask

  initial begin
    test_reset();
    test_cut_through();
    test_full_stall();
    test_store_forward();
    test_too_long();
    test_simul();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
